// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the instruction-fetch port (IF_*)
// and the load/store port (D_*). One requester is granted at a time; its
// command is registered onto the memory bus (M_*). Read data is returned
// on the granted port's registered Readdata bus with a one-cycle Valid
// pulse. A watchdog aborts reads that never complete.
//
// Ports
//   MEMARB_Clk_in / MEMARB_Reset_in  clock, synchronous active-high reset
//   IF_Read_in, IF_Addr_InBUS        fetch read request (held until accepted)
//   IF_Wait_out                      0 only in the cycle the fetch command is accepted
//   IF_Readdata_OutBUS, IF_Valid_out fetch read data + 1-cycle valid pulse
//   D_Read_in, D_Write_in            load/store request (write wins if both)
//   D_Addr_InBUS, D_Byteenable_InBUS, D_Writedata_InBUS   load/store command
//   D_Wait_out                       0 only in the cycle the data command is accepted
//   D_Readdata_OutBUS, D_Valid_out   load data + 1-cycle valid pulse
//   M_Read_out, M_Write_out, M_Addr_OutBUS, M_Byteenable_OutBUS,
//   M_Writedata_OutBUS               registered memory command
//   M_Waitrequest_in                 memory stalls the current command
//   M_Readdata_InBUS, M_Readdatavalid_in   memory read response
//   MEMARB_Timeout_out               sticky: a read was aborted by the watchdog
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int DATAWIDTH     = 32,
    parameter int ADDRWIDTH     = 32,
    parameter int TIMEOUT       = 255,
    parameter int PRIORITY_DATA = 1
) (
    input  logic                   MEMARB_Clk_in,
    input  logic                   MEMARB_Reset_in,

    input  logic                   IF_Read_in,
    input  logic [ADDRWIDTH-1:0]   IF_Addr_InBUS,
    output logic                   IF_Wait_out,
    output logic [DATAWIDTH-1:0]   IF_Readdata_OutBUS,
    output logic                   IF_Valid_out,

    input  logic                   D_Read_in,
    input  logic                   D_Write_in,
    input  logic [ADDRWIDTH-1:0]   D_Addr_InBUS,
    input  logic [DATAWIDTH/8-1:0] D_Byteenable_InBUS,
    input  logic [DATAWIDTH-1:0]   D_Writedata_InBUS,
    output logic                   D_Wait_out,
    output logic [DATAWIDTH-1:0]   D_Readdata_OutBUS,
    output logic                   D_Valid_out,

    output logic                   M_Read_out,
    output logic                   M_Write_out,
    output logic [ADDRWIDTH-1:0]   M_Addr_OutBUS,
    output logic [DATAWIDTH/8-1:0] M_Byteenable_OutBUS,
    output logic [DATAWIDTH-1:0]   M_Writedata_OutBUS,
    input  logic                   M_Waitrequest_in,
    input  logic [DATAWIDTH-1:0]   M_Readdata_InBUS,
    input  logic                   M_Readdatavalid_in,

    output logic                   MEMARB_Timeout_out
);

    // Watchdog counter is at least 8 bits and wide enough to hold TIMEOUT.
    localparam int CNTWIDTH = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    // The abort fires in the TIMEOUT-th RDWAIT cycle, when the count (cleared
    // on entry) still reads TIMEOUT-1.
    localparam logic [CNTWIDTH-1:0] WD_LAST = CNTWIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT} stateType;
    typedef enum logic {PORT_IF, PORT_D} portType;

    stateType              state;
    portType               grant;
    portType               lastServed;
    logic [CNTWIDTH-1:0]   wdCount;

    logic                  ifReq;
    logic                  dReq;
    portType               winner;
    logic                  rdDone;
    logic [DATAWIDTH-1:0]  rdData;

    // Arbitration and read-completion decode.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        ifReq  = IF_Read_in;
        dReq   = D_Read_in | D_Write_in;
        winner = PORT_IF;
        if (dReq && !ifReq) begin
            winner = PORT_D;
        end else if (dReq && ifReq) begin
            if (PRIORITY_DATA != 0) begin
                winner = PORT_D;
            end else begin
                // Round-robin: whoever was not served last takes the tie.
                winner = (lastServed == PORT_IF) ? PORT_D : PORT_IF;
            end
        end

        // A read finishes on returned data or on watchdog expiry; returned
        // data wins if both happen in the same cycle.
        rdDone = M_Readdatavalid_in || ((TIMEOUT != 0) && (wdCount == WD_LAST));
        rdData = M_Readdatavalid_in ? M_Readdata_InBUS : '1;
    end

    // Acceptance is the ISSUE cycle in which memory does not stall.
    assign IF_Wait_out = !((state == ISSUE) && (grant == PORT_IF) && !M_Waitrequest_in);
    assign D_Wait_out  = !((state == ISSUE) && (grant == PORT_D)  && !M_Waitrequest_in);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge MEMARB_Clk_in) begin
        // NOTE: Valid outputs default low each cycle, making them single-cycle pulses.
        IF_Valid_out <= 1'b0;
        D_Valid_out  <= 1'b0;

        if (MEMARB_Reset_in) begin
            state               <= IDLE;
            grant               <= PORT_IF;
            lastServed          <= PORT_IF;
            wdCount             <= '0;
            M_Read_out          <= 1'b0;
            M_Write_out         <= 1'b0;
            M_Addr_OutBUS       <= '0;
            M_Byteenable_OutBUS <= '0;
            M_Writedata_OutBUS  <= '0;
            IF_Readdata_OutBUS  <= '0;
            D_Readdata_OutBUS   <= '0;
            MEMARB_Timeout_out  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (ifReq || dReq) begin
                        grant      <= winner;
                        lastServed <= winner;
                        state      <= ISSUE;
                        if (winner == PORT_D) begin
                            // D_Write_in overrides a simultaneous D_Read_in.
                            M_Read_out          <= !D_Write_in;
                            M_Write_out         <= D_Write_in;
                            M_Addr_OutBUS       <= D_Addr_InBUS;
                            M_Byteenable_OutBUS <= D_Byteenable_InBUS;
                            M_Writedata_OutBUS  <= D_Writedata_InBUS;
                        end else begin
                            M_Read_out          <= 1'b1;
                            M_Write_out         <= 1'b0;
                            M_Addr_OutBUS       <= IF_Addr_InBUS;
                            M_Byteenable_OutBUS <= '1;
                            M_Writedata_OutBUS  <= '0;
                        end
                    end
                end

                ISSUE: begin
                    if (!M_Waitrequest_in) begin
                        M_Read_out  <= 1'b0;
                        M_Write_out <= 1'b0;
                        wdCount     <= '0;
                        // M_Write_out still holds the latched command kind here.
                        state       <= M_Write_out ? IDLE : RDWAIT;
                    end
                end

                RDWAIT: begin
                    if (rdDone) begin
                        if (grant == PORT_IF) begin
                            IF_Readdata_OutBUS <= rdData;
                            IF_Valid_out       <= 1'b1;
                        end else begin
                            D_Readdata_OutBUS  <= rdData;
                            D_Valid_out        <= 1'b1;
                        end
                        if (!M_Readdatavalid_in) begin
                            MEMARB_Timeout_out <= 1'b1;
                        end
                        state <= IDLE;
                    end else if (wdCount != '1) begin
                        wdCount <= wdCount + CNTWIDTH'(1);
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Two arbiter instances: dut0 (data priority, watchdog TIMEOUT=4) and dut1
// (round-robin, watchdog disabled). Each is exercised in turn by requester
// scripts and a memory responder. The reference model is a transaction
// schedule: when a request is granted, the cycles of its memory strobe,
// acceptance, data return and Valid pulse are computed arithmetically from
// the memory stall/latency chosen for it, and every DUT output is compared
// with that schedule every cycle.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

    localparam int NEVER = 1000;
    localparam int PRIO [2] = '{1, 0};
    localparam int TMO  [2] = '{4, 0};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      [2];
    logic        ifRead   [2];
    logic [31:0] ifAddr   [2];
    logic        ifWait   [2];
    logic [31:0] ifRdata  [2];
    logic        ifValid  [2];
    logic        dRead    [2];
    logic        dWrite   [2];
    logic [31:0] dAddr    [2];
    logic [3:0]  dBe      [2];
    logic [31:0] dWdata   [2];
    logic        dWait    [2];
    logic [31:0] dRdata   [2];
    logic        dValid   [2];
    logic        mRead    [2];
    logic        mWrite   [2];
    logic [31:0] mAddr    [2];
    logic [3:0]  mBe      [2];
    logic [31:0] mWdata   [2];
    logic        mWaitreq [2];
    logic [31:0] mRdata   [2];
    logic        mRdvalid [2];
    logic        tmo      [2];

    mem_port_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(32), .TIMEOUT(4), .PRIORITY_DATA(1)) dut0 (
        .MEMARB_Clk_in(clk), .MEMARB_Reset_in(rst[0]),
        .IF_Read_in(ifRead[0]), .IF_Addr_InBUS(ifAddr[0]), .IF_Wait_out(ifWait[0]),
        .IF_Readdata_OutBUS(ifRdata[0]), .IF_Valid_out(ifValid[0]),
        .D_Read_in(dRead[0]), .D_Write_in(dWrite[0]), .D_Addr_InBUS(dAddr[0]),
        .D_Byteenable_InBUS(dBe[0]), .D_Writedata_InBUS(dWdata[0]), .D_Wait_out(dWait[0]),
        .D_Readdata_OutBUS(dRdata[0]), .D_Valid_out(dValid[0]),
        .M_Read_out(mRead[0]), .M_Write_out(mWrite[0]), .M_Addr_OutBUS(mAddr[0]),
        .M_Byteenable_OutBUS(mBe[0]), .M_Writedata_OutBUS(mWdata[0]),
        .M_Waitrequest_in(mWaitreq[0]), .M_Readdata_InBUS(mRdata[0]),
        .M_Readdatavalid_in(mRdvalid[0]), .MEMARB_Timeout_out(tmo[0])
    );

    mem_port_arbiter #(.DATAWIDTH(32), .ADDRWIDTH(32), .TIMEOUT(0), .PRIORITY_DATA(0)) dut1 (
        .MEMARB_Clk_in(clk), .MEMARB_Reset_in(rst[1]),
        .IF_Read_in(ifRead[1]), .IF_Addr_InBUS(ifAddr[1]), .IF_Wait_out(ifWait[1]),
        .IF_Readdata_OutBUS(ifRdata[1]), .IF_Valid_out(ifValid[1]),
        .D_Read_in(dRead[1]), .D_Write_in(dWrite[1]), .D_Addr_InBUS(dAddr[1]),
        .D_Byteenable_InBUS(dBe[1]), .D_Writedata_InBUS(dWdata[1]), .D_Wait_out(dWait[1]),
        .D_Readdata_OutBUS(dRdata[1]), .D_Valid_out(dValid[1]),
        .M_Read_out(mRead[1]), .M_Write_out(mWrite[1]), .M_Addr_OutBUS(mAddr[1]),
        .M_Byteenable_OutBUS(mBe[1]), .M_Writedata_OutBUS(mWdata[1]),
        .M_Waitrequest_in(mWaitreq[1]), .M_Readdata_InBUS(mRdata[1]),
        .M_Readdatavalid_in(mRdvalid[1]), .MEMARB_Timeout_out(tmo[1])
    );

    // One request as seen by a requester, plus the memory behaviour it will meet.
    typedef struct {
        bit          write;
        bit          both;    // drive D_Read_in together with D_Write_in
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          stall;   // waitrequest cycles before acceptance
        int          lat;     // RDWAIT cycles before data returns
        int          gap;     // idle cycles before the request is raised
    } reqT;

    reqT ifQ [$];
    reqT dQ  [$];

    // Model state (port index 0 = fetch, 1 = data).
    int          cyc;
    int          curDut;
    reqT         cur [2];
    bit          active [2];
    int          freeFrom [2];
    int          lastServed;
    bit          txnValid;
    reqT         txn;
    int          txnPort, txnStart, txnAccept, txnFree;
    bit          txnAbort;
    bit          pendValid;
    int          pendPort, pendAt;
    logic [31:0] pendData;
    bit          pendTimeout;
    logic [31:0] lastData [2];
    bit          expTimeout;

    int compared   = 0;
    int mismatched = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d cycle %0d: got 0x%08h expected 0x%08h", tag, curDut, cyc, got, exp);
        end
    endtask

    function automatic reqT mkReq(bit write, logic [31:0] addr, logic [3:0] be, logic [31:0] wdata,
                                  logic [31:0] rdata, int stall, int lat, int gap);
        reqT r;
        r.write = write; r.both = 1'b0; r.addr = addr; r.be = be; r.wdata = wdata;
        r.rdata = rdata; r.stall = stall; r.lat = lat; r.gap = gap;
        return r;
    endfunction

    function automatic reqT randReq(int q, int u);
        reqT r;
        r.write = (q == 1) && ($urandom_range(0, 2) == 0);
        r.both  = r.write && ($urandom_range(0, 3) == 0);
        r.addr  = $urandom();
        r.be    = 4'($urandom());
        r.wdata = $urandom();
        r.rdata = $urandom();
        r.stall = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
        r.lat   = (TMO[u] != 0) ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 12));
        r.gap   = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 4));
        return r;
    endfunction

    function automatic void resetModel();
        txnValid = 1'b0; pendValid = 1'b0; expTimeout = 1'b0; lastServed = 0;
        for (int q = 0; q < 2; q++) begin
            active[q] = 1'b0; freeFrom[q] = cyc; lastData[q] = '0;
        end
        ifQ.delete();
        dQ.delete();
    endfunction

    // A fresh grant: lay out the whole transaction timeline.
    function automatic void grantNext(int u);
        int win;
        if (active[0] && active[1]) win = (PRIO[u] != 0 || lastServed == 0) ? 1 : 0;
        else                        win = active[1] ? 1 : 0;
        lastServed = win;
        txn        = cur[win];
        txnPort    = win;
        txnValid   = 1'b1;
        txnStart   = cyc;
        txnAccept  = cyc + 1 + txn.stall;
        txnAbort   = 1'b0;
        if (txn.write) begin
            txnFree = txnAccept + 1;
        end else begin
            pendValid = 1'b1;
            pendPort  = win;
            if (TMO[u] != 0 && txn.lat >= TMO[u]) begin
                txnAbort    = 1'b1;
                txnFree     = txnAccept + 1 + TMO[u];
                pendData    = '1;
                pendTimeout = 1'b1;
            end else begin
                txnFree     = txnAccept + 2 + txn.lat;
                pendData    = txn.rdata;
                pendTimeout = 1'b0;
            end
            pendAt = txnFree;
        end
    endfunction

    // Entered 1 time unit after a rising edge; drives cycle `cyc`, checks, advances.
    task automatic stepCycle(input int u);
        bit expV [2];
        bit inIssue, inRdwait, accept;
        expV[0] = 1'b0;
        expV[1] = 1'b0;
        if (pendValid && cyc == pendAt) begin
            expV[pendPort]     = 1'b1;
            lastData[pendPort] = pendData;
            if (pendTimeout) expTimeout = 1'b1;
            pendValid = 1'b0;
        end
        if (txnValid && cyc == txnFree) txnValid = 1'b0;
        if (!active[0] && ifQ.size() > 0 && cyc >= freeFrom[0] + ifQ[0].gap) begin
            cur[0] = ifQ.pop_front(); active[0] = 1'b1;
        end
        if (!active[1] && dQ.size() > 0 && cyc >= freeFrom[1] + dQ[0].gap) begin
            cur[1] = dQ.pop_front(); active[1] = 1'b1;
        end
        if (!txnValid && (active[0] || active[1])) grantNext(u);

        inIssue  = txnValid && cyc > txnStart && cyc <= txnAccept;
        inRdwait = txnValid && !txn.write && cyc > txnAccept;
        accept   = inIssue && cyc == txnAccept;

        ifRead[u] = active[0];
        ifAddr[u] = active[0] ? cur[0].addr : $urandom();
        dWrite[u] = active[1] && cur[1].write;
        dRead[u]  = active[1] && (!cur[1].write || cur[1].both);
        dAddr[u]  = active[1] ? cur[1].addr : $urandom();
        dBe[u]    = active[1] ? cur[1].be : 4'($urandom());
        dWdata[u] = active[1] ? cur[1].wdata : $urandom();
        mWaitreq[u] = inIssue ? (cyc < txnAccept) : 1'($urandom_range(0, 1));
        if (inRdwait) begin
            mRdvalid[u] = !txnAbort && (cyc == txnAccept + 1 + txn.lat);
            mRdata[u]   = mRdvalid[u] ? txn.rdata : $urandom();
        end else begin
            // Stray valids outside RDWAIT must be ignored.
            mRdvalid[u] = ($urandom_range(0, 5) == 0);
            mRdata[u]   = $urandom();
        end
        #1;

        check("M_Read",  32'(mRead[u]),  32'(inIssue && !txn.write));
        check("M_Write", 32'(mWrite[u]), 32'(inIssue && txn.write));
        if (inIssue) begin
            check("M_Addr", mAddr[u], txn.addr);
            check("M_Be",   32'(mBe[u]), 32'((txnPort == 0) ? 4'hF : txn.be));
            if (txn.write) check("M_Wdata", mWdata[u], txn.wdata);
        end
        check("IF_Wait",     32'(ifWait[u]),  32'(!(accept && txnPort == 0)));
        check("D_Wait",      32'(dWait[u]),   32'(!(accept && txnPort == 1)));
        check("IF_Valid",    32'(ifValid[u]), 32'(expV[0]));
        check("D_Valid",     32'(dValid[u]),  32'(expV[1]));
        check("IF_Readdata", ifRdata[u], lastData[0]);
        check("D_Readdata",  dRdata[u],  lastData[1]);
        check("Timeout",     32'(tmo[u]), 32'(expTimeout));

        if (accept) begin
            active[txnPort]   = 1'b0;
            freeFrom[txnPort] = cyc + 1;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic runCycles(input int u, input int n);
        for (int i = 0; i < n; i++) stepCycle(u);
    endtask

    task automatic runUntilIdle(input int u, input int budget);
        int n = 0;
        while (ifQ.size() > 0 || dQ.size() > 0 || active[0] || active[1] || txnValid || pendValid) begin
            if (n >= budget) begin
                check("cycle_budget", 32'(n), 32'(budget + 1));
                break;
            end
            stepCycle(u);
            n++;
        end
    endtask

    task automatic applyReset(input int u);
        rst[u] = 1'b1; ifRead[u] = 1'b0; dRead[u] = 1'b0; dWrite[u] = 1'b0;
        mWaitreq[u] = 1'b0; mRdvalid[u] = 1'b0;
        @(posedge clk);
        #1;
        rst[u] = 1'b0;
        cyc++;
        resetModel();
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; ifRead[u] = 1'b0; ifAddr[u] = '0; dRead[u] = 1'b0; dWrite[u] = 1'b0;
            dAddr[u] = '0; dBe[u] = '0; dWdata[u] = '0; mWaitreq[u] = 1'b0; mRdata[u] = '0;
            mRdvalid[u] = 1'b0;
        end
        cyc = 0;
        curDut = 0;
        repeat (2) @(posedge clk);
        #1;
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        resetModel();

        // ---- dut0: data priority, TIMEOUT=4 ----
        runCycles(0, 2);
        // Zero-wait fetch read.
        ifQ.push_back(mkReq(1'b0, 32'h100, 4'h0, 32'h0, 32'h00500093, 0, 0, 0));
        runUntilIdle(0, 50);
        // Simultaneous fetch and data reads: data first.
        ifQ.push_back(mkReq(1'b0, 32'h200, 4'h0, 32'h0, 32'h11111111, 0, 0, 0));
        dQ.push_back(mkReq(1'b0, 32'h300, 4'hC, 32'h0, 32'h22222222, 0, 1, 0));
        runUntilIdle(0, 50);
        // Stalled write held for four strobe cycles.
        dQ.push_back(mkReq(1'b1, 32'h2004, 4'b0011, 32'hDEADBEEF, 32'h0, 3, 0, 0));
        runUntilIdle(0, 50);
        // Back-to-back writes.
        for (int i = 0; i < 3; i++)
            dQ.push_back(mkReq(1'b1, 32'h3000 + 32'(4 * i), 4'hF, 32'hA5A50000 + 32'(i), 32'h0, 0, 0, 0));
        runUntilIdle(0, 50);
        // Read that never returns: watchdog abort, sticky flag, late valids ignored.
        dQ.push_back(mkReq(1'b0, 32'h400, 4'hF, 32'h0, 32'h0, 0, NEVER, 0));
        runUntilIdle(0, 50);
        runCycles(0, 8);
        applyReset(0);
        runCycles(0, 2);
        for (int i = 0; i < 60; i++) begin
            ifQ.push_back(randReq(0, 0));
            dQ.push_back(randReq(1, 0));
        end
        runUntilIdle(0, 4000);

        // ---- dut1: round-robin, watchdog disabled ----
        curDut = 1;
        applyReset(1);
        runCycles(1, 2);
        for (int i = 0; i < 2; i++) begin
            dQ.push_back(mkReq(1'b0, 32'h500 + 32'(i), 4'hF, 32'h0, 32'hD0D0D000 + 32'(i), 0, 0, 0));
            ifQ.push_back(mkReq(1'b0, 32'h600 + 32'(i), 4'h0, 32'h0, 32'hF0F0F000 + 32'(i), 0, 0, 0));
        end
        runUntilIdle(1, 50);
        // Reset in the middle of an outstanding read, then a normal fetch.
        dQ.push_back(mkReq(1'b0, 32'h700, 4'hF, 32'h0, 32'h0, 0, NEVER, 0));
        runCycles(1, 6);
        applyReset(1);
        runCycles(1, 1);
        ifQ.push_back(mkReq(1'b0, 32'h104, 4'h0, 32'h0, 32'h00A00113, 0, 0, 0));
        runUntilIdle(1, 50);
        for (int i = 0; i < 60; i++) begin
            ifQ.push_back(randReq(0, 1));
            dQ.push_back(randReq(1, 1));
        end
        runUntilIdle(1, 4000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
